// File: rtl/multicycle_controller.sv
// Main sequencing FSM for the multi-cycle MIPS datapath: fetch/decode/execute
// steps, Moore-decoded control, optional memory wait states and halt on illegal op.
module multicycle_controller #(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       pcen,
    output logic       halted,
    output logic [3:0] state
);

    // state   | meaning
    // FETCH   | read instruction at PC, PC += 4
    // DECODE  | read registers, precompute branch target
    // MEMADR  | effective address for lw/sw
    // MEMRD   | memory read at ALUOut
    // MEMWB   | write MDR to rt
    // MEMWR   | memory write at ALUOut
    // EXECUTE | R-type ALU operation
    // ALUWB   | write ALUOut to rd
    // BRANCH  | beq compare, conditional PC load
    // ADDIEX  | addi ALU operation
    // ADDIWB  | write ALUOut to rt
    // JUMP    | PC <- jump target
    // HALT    | illegal instruction, wait for reset
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11,
        S_HALT    = 4'd15
    } state_e;

    localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       wait_last;
    logic       funct_ok;
    logic [2:0] funct_alu;
    logic       irwrite_c, regwrite_c, memwrite_c, pcwrite_c, branch_c;

    assign wait_last = (cnt_q == WAIT_LAST);

    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = 3'b000;
        case (funct)
            6'b100000: funct_alu = 3'b010;
            6'b100010: funct_alu = 3'b110;
            6'b100100: funct_alu = 3'b000;
            6'b100101: funct_alu = 3'b001;
            6'b101010: funct_alu = 3'b111;
            default:   funct_ok  = 1'b0;
        endcase
    end

    // Counter only runs in the three memory-access states and clears on every exit.
    always_comb begin
        state_d = state_q;
        cnt_d   = 3'd0;
        case (state_q)
            S_FETCH: begin
                if (wait_last) state_d = S_DECODE;
                else           cnt_d   = cnt_q + 3'd1;
            end
            S_DECODE: begin
                case (op)
                    6'b100011, 6'b101011: state_d = S_MEMADR;
                    6'b000000:            state_d = funct_ok ? S_EXECUTE : S_HALT;
                    6'b000100:            state_d = S_BRANCH;
                    6'b001000:            state_d = S_ADDIEX;
                    6'b000010:            state_d = S_JUMP;
                    default:              state_d = S_HALT;
                endcase
            end
            S_MEMADR:  state_d = (op == 6'b101011) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (wait_last) state_d = S_MEMWB;
                else           cnt_d   = cnt_q + 3'd1;
            end
            S_MEMWR: begin
                if (wait_last) state_d = S_FETCH;
                else           cnt_d   = cnt_q + 3'd1;
            end
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_HALT:    state_d = S_HALT;
            default:   state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        irwrite_c  = 1'b0;
        regwrite_c = 1'b0;
        memwrite_c = 1'b0;
        pcwrite_c  = 1'b0;
        branch_c   = 1'b0;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        alucontrol = 3'b000;
        case (state_q)
            S_FETCH: begin
                alusrcb    = 2'b01;
                alucontrol = 3'b010;
                irwrite_c  = wait_last;
                pcwrite_c  = wait_last;
            end
            S_DECODE: begin
                alusrcb    = 2'b11;
                alucontrol = 3'b010;
            end
            S_MEMADR, S_ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = 3'b010;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                memtoreg   = 1'b1;
                regwrite_c = 1'b1;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                memwrite_c = wait_last;
            end
            S_EXECUTE: begin
                alusrca    = 1'b1;
                alucontrol = funct_alu;
            end
            S_ALUWB: begin
                regdst     = 1'b1;
                regwrite_c = 1'b1;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = 3'b110;
                pcsrc      = 2'b01;
                branch_c   = 1'b1;
            end
            S_ADDIWB: regwrite_c = 1'b1;
            S_JUMP: begin
                pcsrc     = 2'b10;
                pcwrite_c = 1'b1;
            end
            default: ;
        endcase
    end

    // State sits at FETCH during reset; gating keeps its final-wait enables quiet.
    assign irwrite  = irwrite_c & reset;
    assign regwrite = regwrite_c & reset;
    assign memwrite = memwrite_c & reset;
    assign pcen     = (pcwrite_c | (branch_c & zero)) & reset;
    assign halted   = (state_q == S_HALT);
    assign state    = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle expectations queued when an
// instruction is driven, popped and compared each falling edge. Two instances (wait 0/2).
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst0, rst2;
    logic [5:0] op, funct;
    logic       zero;

    logic       mw0, ir0, rw0, io0, m2r0, rd0, asa0, pcen0, h0;
    logic [1:0] asb0, pcs0;
    logic [2:0] alu0;
    logic [3:0] st0;
    logic       mw2, ir2, rw2, io2, m2r2, rd2, asa2, pcen2, h2;
    logic [1:0] asb2, pcs2;
    logic [2:0] alu2;
    logic [3:0] st2;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      tag;
        bit         sel;
        logic [3:0] st;
        logic [4:0] en;
        bit         chk_aux;
        logic [7:0] aux;
    } exp_t;

    exp_t q[$];
    bit   cur_sel = 1'b0;

    always #5 clk = ~clk;

    multicycle_controller #(.MEM_WAIT(0)) dut0 (
        .clk(clk), .reset(rst0), .op(op), .funct(funct), .zero(zero),
        .memwrite(mw0), .irwrite(ir0), .regwrite(rw0), .iord(io0), .memtoreg(m2r0),
        .regdst(rd0), .alusrca(asa0), .alusrcb(asb0), .pcsrc(pcs0), .alucontrol(alu0),
        .pcen(pcen0), .halted(h0), .state(st0)
    );

    multicycle_controller #(.MEM_WAIT(2)) dut2 (
        .clk(clk), .reset(rst2), .op(op), .funct(funct), .zero(zero),
        .memwrite(mw2), .irwrite(ir2), .regwrite(rw2), .iord(io2), .memtoreg(m2r2),
        .regdst(rd2), .alusrca(asa2), .alusrcb(asb2), .pcsrc(pcs2), .alucontrol(alu2),
        .pcen(pcen2), .halted(h2), .state(st2)
    );

    // en = {irwrite, pcen, memwrite, regwrite, halted}
    function automatic logic [4:0] obs_en(bit sel);
        return sel ? {ir2, pcen2, mw2, rw2, h2} : {ir0, pcen0, mw0, rw0, h0};
    endfunction

    // aux = {memtoreg, regdst, pcsrc, alucontrol, iord}
    function automatic logic [7:0] obs_aux(bit sel);
        return sel ? {m2r2, rd2, pcs2, alu2, io2} : {m2r0, rd0, pcs0, alu0, io0};
    endfunction

    function automatic logic [7:0] mk_aux(logic m, logic rd, logic [1:0] pc,
                                          logic [2:0] alu, logic io);
        return {m, rd, pc, alu, io};
    endfunction

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(string tag, logic [3:0] st, logic [4:0] en,
                        bit ca = 1'b0, logic [7:0] aux = 8'h00);
        exp_t e;
        e.tag = tag; e.sel = cur_sel; e.st = st; e.en = en;
        e.chk_aux = ca; e.aux = aux;
        q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (q.size() > 0) begin
            @(negedge clk);
            e = q.pop_front();
            chk({e.tag, ".state"}, 16'(e.sel ? st2 : st0), 16'(e.st));
            chk({e.tag, ".en"}, 16'(obs_en(e.sel)), 16'(e.en));
            if (e.chk_aux) chk({e.tag, ".aux"}, 16'(obs_aux(e.sel)), 16'(e.aux));
        end
    endtask

    initial begin
        rst0 = 1'b0; rst2 = 1'b0;
        op = 6'b100011; funct = 6'b000000; zero = 1'b0;

        // Both instances held in reset: FETCH, enables forced low.
        cur_sel = 1'b0;
        push("rst0_a", 4'd0, 5'b00000, 1'b1, mk_aux(0, 0, 2'b00, 3'b010, 0));
        push("rst0_b", 4'd0, 5'b00000);
        cur_sel = 1'b1;
        push("rst2", 4'd0, 5'b00000);
        drain();

        // lw, MEM_WAIT = 0
        cur_sel = 1'b0;
        @(posedge clk); #1 rst0 = 1'b1;
        push("lw_fetch", 4'd0, 5'b11000, 1'b1, mk_aux(0, 0, 2'b00, 3'b010, 0));
        push("lw_dec",   4'd1, 5'b00000);
        push("lw_madr",  4'd2, 5'b00000, 1'b1, mk_aux(0, 0, 2'b00, 3'b010, 0));
        push("lw_mrd",   4'd3, 5'b00000, 1'b1, mk_aux(0, 0, 2'b00, 3'b000, 1));
        push("lw_mwb",   4'd4, 5'b00010, 1'b1, mk_aux(1, 0, 2'b00, 3'b000, 0));
        push("lw_next",  4'd0, 5'b11000);
        drain();

        // R-type sub
        op = 6'b000000; funct = 6'b100010;
        push("sub_dec", 4'd1, 5'b00000);
        push("sub_ex",  4'd6, 5'b00000, 1'b1, mk_aux(0, 0, 2'b00, 3'b110, 0));
        push("sub_wb",  4'd7, 5'b00010, 1'b1, mk_aux(0, 1, 2'b00, 3'b000, 0));
        push("sub_next", 4'd0, 5'b11000);
        drain();

        // R-type slt
        funct = 6'b101010;
        push("slt_dec", 4'd1, 5'b00000);
        push("slt_ex",  4'd6, 5'b00000, 1'b1, mk_aux(0, 0, 2'b00, 3'b111, 0));
        push("slt_wb",  4'd7, 5'b00010);
        push("slt_next", 4'd0, 5'b11000);
        drain();

        // beq taken then not taken
        op = 6'b000100; zero = 1'b1;
        push("beq1_dec", 4'd1, 5'b00000);
        push("beq1_br",  4'd8, 5'b01000, 1'b1, mk_aux(0, 0, 2'b01, 3'b110, 0));
        push("beq1_next", 4'd0, 5'b11000);
        drain();
        zero = 1'b0;
        push("beq0_dec", 4'd1, 5'b00000);
        push("beq0_br",  4'd8, 5'b00000, 1'b1, mk_aux(0, 0, 2'b01, 3'b110, 0));
        push("beq0_next", 4'd0, 5'b11000);
        drain();

        // addi
        op = 6'b001000;
        push("addi_dec", 4'd1, 5'b00000);
        push("addi_ex",  4'd9, 5'b00000, 1'b1, mk_aux(0, 0, 2'b00, 3'b010, 0));
        push("addi_wb",  4'd10, 5'b00010, 1'b1, mk_aux(0, 0, 2'b00, 3'b000, 0));
        push("addi_next", 4'd0, 5'b11000);
        drain();

        // j
        op = 6'b000010;
        push("j_dec",  4'd1, 5'b00000);
        push("j_jump", 4'd11, 5'b01000, 1'b1, mk_aux(0, 0, 2'b10, 3'b000, 0));
        push("j_next", 4'd0, 5'b11000);
        drain();

        // Illegal opcode: HALT until reset
        op = 6'b111111;
        push("ill_dec", 4'd1, 5'b00000);
        for (int i = 0; i < 10; i++) push($sformatf("ill_halt%0d", i), 4'd15, 5'b00001);
        drain();
        #2 rst0 = 1'b0;
        #1;
        chk("halt_rst_state", 16'(st0), 16'd0);
        chk("halt_rst_halted", 16'(h0), 16'd0);
        @(posedge clk); #1 rst0 = 1'b1;
        push("halt_exit", 4'd0, 5'b11000);
        drain();

        // R-type with unsupported funct
        op = 6'b000000; funct = 6'b000000;
        push("badf_dec", 4'd1, 5'b00000);
        for (int i = 0; i < 3; i++) push($sformatf("badf_halt%0d", i), 4'd15, 5'b00001);
        drain();
        rst0 = 1'b0;

        // sw, MEM_WAIT = 2: 3-cycle FETCH and MEMWR, strobe on last cycle only
        cur_sel = 1'b1;
        op = 6'b101011;
        @(posedge clk); #1 rst2 = 1'b1;
        push("sw_f0",  4'd0, 5'b00000);
        push("sw_f1",  4'd0, 5'b00000);
        push("sw_f2",  4'd0, 5'b11000);
        push("sw_dec", 4'd1, 5'b00000);
        push("sw_madr", 4'd2, 5'b00000);
        push("sw_w0",  4'd5, 5'b00000, 1'b1, mk_aux(0, 0, 2'b00, 3'b000, 1));
        push("sw_w1",  4'd5, 5'b00000);
        push("sw_w2",  4'd5, 5'b00100, 1'b1, mk_aux(0, 0, 2'b00, 3'b000, 1));
        push("sw_next", 4'd0, 5'b00000);
        drain();

        // Second sw aborted by reset in the first MEMWR cycle
        push("swr_f1",  4'd0, 5'b00000);
        push("swr_f2",  4'd0, 5'b11000);
        push("swr_dec", 4'd1, 5'b00000);
        push("swr_madr", 4'd2, 5'b00000);
        push("swr_w0",  4'd5, 5'b00000);
        drain();
        #2 rst2 = 1'b0;
        #1;
        chk("abort_state_async", 16'(st2), 16'd0);
        chk("abort_memwrite", 16'(mw2), 16'd0);
        for (int i = 0; i < 3; i++) push($sformatf("abort_hold%0d", i), 4'd0, 5'b00000);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
